serial_adder_seq: RTL
=====================

Name: serial_adder_seq

Overview:
Bit-serial ripple adder that is the additive counterpart to the team's half subtractor. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It adds one bit per clock, LSB first, through a single full-adder cell and a carry flop. It returns the sum and carry-out over a second valid/ready handshake. It is used where area matters more than throughput, such as accumulator updates in slow control paths.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set a/b/cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  addend A, unsigned
b  input  WIDTH  addend B, unsigned
cin  input  1  carry-in
out_valid  output  1  sum/cout valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. Assertion immediately forces all state; deassertion is used synchronously.
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, sum = 0, cout = 0.
  - Operand shift registers, carry flop and bit counter all = 0.
- FSM has three states: IDLE, RUN and DONE.
  - in_ready = (state == IDLE), decoded from the state flops.
  - out_valid = (state == DONE), registered by state.
- IDLE:
  - On a rising edge with in_valid = 1, load a into shreg_a, b into shreg_b, cin into the carry flop, and set count = 0. Go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - s = shreg_a[0] ^ shreg_b[0] ^ carry.
  - carry <= (shreg_a[0] & shreg_b[0]) | (carry & (shreg_a[0] ^ shreg_b[0])).
  - shreg_a and shreg_b shift right by 1. sum_sh shifts right with s inserted at its MSB. count increments.
  - On the edge where count == WIDTH-1, also load the result register: sum <= {s, sum_sh[WIDTH-1:1]} and cout <= the new carry. Go to DONE.
- Latency: if the input handshake completes on edge T, out_valid is high after edge T+WIDTH. That is exactly WIDTH RUN edges.
- DONE:
  - Hold sum and cout stable.
  - When out_ready = 1 on an edge, go to IDLE.
  - While out_ready = 0, stay in DONE indefinitely with all outputs held (backpressure).
- sum and cout are driven only from the result register. They change solely on the RUN to DONE edge and keep the last result across IDLE/RUN until the next completion.
- Throughput: there is no overlap between operations. If in_valid and out_ready are both 1 in DONE, only the output handshake completes. The next operand is accepted no earlier than the following cycle in IDLE (one bubble). Best case is one operation per WIDTH+2 cycles.
- in_valid is ignored and operand inputs are don't-care outside IDLE. The upstream must hold a/b/cin stable only during the accepting cycle.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry of the (WIDTH+1)-bit sum. Wrap-around case: all-ones + 1 gives sum = 0 and cout = 1.
- The bit counter is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- Reset mid-operation (rst_n low in RUN or DONE): the operation is abandoned and all registers return to their reset values. No out_valid pulse occurs for the abandoned operation. in_ready = 1 on the first edge after release.
- X-safety: out_valid and in_ready must never be X after reset.

Test Plan:
- WIDTH=8: a=0x5A, b=0x33, cin=0 accepted at edge T, out_ready=1 -> out_valid rises after edge T+8; sum=0x8D, cout=0; in_ready low edges T+1..T+9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum/cout are unchanged. Raise out_ready -> IDLE next edge, in_ready=1.
- in_valid=1 with a=0x11 pulsed during RUN of 0x10+0x20 -> ignored; result is 0x30, cout=0.
- Simultaneous in_valid and out_ready in DONE -> result retires. The new operand is taken only on a later IDLE cycle, and its result arrives correctly.
- Assert rst_n low at the 4th RUN cycle -> outputs go to reset values immediately, no out_valid. After release, a=0x80 + b=0x80 -> sum=0x00, cout=1.
- Randomized 1000 operations at WIDTH=8 and WIDTH=16 with random handshake stalls -> every result matches the reference model of (a+b+cin).

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell plus a carry flop add two WIDTH-bit
// operands LSB first, with valid/ready handshakes on both operands and result.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shreg_a_q,  shreg_a_d;
    logic [WIDTH-1:0] shreg_b_q,  shreg_b_d;
    logic [WIDTH-1:0] sum_sh_q,   sum_sh_d;
    logic [WIDTH-1:0] sum_q,      sum_d;
    logic             carry_q,    carry_d;
    logic             cout_q,     cout_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             fa_sum;
    logic             fa_carry;

    // Full-adder cell on the current LSBs, next-state logic for the FSM and datapath
    always_comb begin
        fa_sum    = shreg_a_q[0] ^ shreg_b_q[0] ^ carry_q;
        fa_carry  = (shreg_a_q[0] & shreg_b_q[0]) | (carry_q & (shreg_a_q[0] ^ shreg_b_q[0]));
        state_d   = state_q;
        shreg_a_d = shreg_a_q;
        shreg_b_d = shreg_b_q;
        sum_sh_d  = sum_sh_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_a_d = a;
                    shreg_b_d = b;
                    carry_d   = cin;
                    count_d   = CNT_ZERO;
                    state_d   = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d   = fa_carry;
                shreg_a_d = {1'b0, shreg_a_q[WIDTH-1:1]};
                shreg_b_d = {1'b0, shreg_b_q[WIDTH-1:1]};
                sum_sh_d  = {fa_sum, sum_sh_q[WIDTH-1:1]};
                // Counter parks at zero instead of wrapping so it stays within WIDTH-1
                if (count_q == CNT_LAST) begin
                    sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    count_d = CNT_ZERO;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_a_q <= {WIDTH{1'b0}};
            shreg_b_q <= {WIDTH{1'b0}};
            sum_sh_q  <= {WIDTH{1'b0}};
            sum_q     <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            count_q   <= CNT_ZERO;
        end else begin
            state_q   <= state_d;
            shreg_a_q <= shreg_a_d;
            shreg_b_q <= shreg_b_d;
            sum_sh_q  <= sum_sh_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            count_q   <= count_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
